cp0_tlb_ctrl: RTL and testbench

//  CP0-side manager for the 32-entry joint TLB. Owns the Index, Random, Wired, EntryHi, PageMask,

---
 rtl/cp0_tlb_ctrl_if.sv | 46 ++++
 rtl/cp0_tlb_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cp0_tlb_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_tlb_ctrl_if.sv
// Bundle between the CP0 TLB controller and its surroundings: the pipeline's
// instruction/MTC0/MFC0 signals plus the TLB write, read and probe ports.
interface cp0_tlb_ctrl_if #(
    parameter int IDX_W = 5
);
    logic             inst_valid;
    logic [1:0]       inst_op;
    logic             busy;
    logic             done;
    logic             cp0_we;
    logic [4:0]       cp0_addr;
    logic [31:0]      cp0_wdata;
    logic [31:0]      cp0_rdata;
    logic             tlb_we;
    logic [IDX_W-1:0] tlb_widx;
    logic [31:0]      tlb_entryhi;
    logic [31:0]      tlb_pagemask;
    logic [31:0]      tlb_entrylo0;
    logic [31:0]      tlb_entrylo1;
    logic [IDX_W-1:0] tlb_ridx;
    logic [31:0]      tlb_r_entryhi;
    logic [31:0]      tlb_r_pagemask;
    logic [31:0]      tlb_r_entrylo0;
    logic [31:0]      tlb_r_entrylo1;
    logic             tlb_probe_req;
    logic             tlb_probe_hit;
    logic [IDX_W-1:0] tlb_probe_idx;

    modport master (
        input  inst_valid, inst_op, cp0_we, cp0_addr, cp0_wdata,
        input  tlb_r_entryhi, tlb_r_pagemask, tlb_r_entrylo0, tlb_r_entrylo1,
        input  tlb_probe_hit, tlb_probe_idx,
        output busy, done, cp0_rdata,
        output tlb_we, tlb_widx, tlb_entryhi, tlb_pagemask, tlb_entrylo0, tlb_entrylo1,
        output tlb_ridx, tlb_probe_req
    );

    modport slave (
        output inst_valid, inst_op, cp0_we, cp0_addr, cp0_wdata,
        output tlb_r_entryhi, tlb_r_pagemask, tlb_r_entrylo0, tlb_r_entrylo1,
        output tlb_probe_hit, tlb_probe_idx,
        input  busy, done, cp0_rdata,
        input  tlb_we, tlb_widx, tlb_entryhi, tlb_pagemask, tlb_entrylo0, tlb_entrylo1,
        input  tlb_ridx, tlb_probe_req
    );
endinterface

// File: rtl/cp0_tlb_ctrl.sv
// CP0-side TLB manager: holds Index/Random/Wired/EntryHi/PageMask/EntryLo0/1 and
// sequences TLBR, TLBWI, TLBWR and TLBP onto the joint TLB's ports.
module cp0_tlb_ctrl #(
    parameter int N_ENTRIES = 32,
    parameter int IDX_W     = 5
) (
    input  logic           clk,
    input  logic           rst,
    cp0_tlb_ctrl_if.master bus
);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_ENTRIES - 1);
    localparam logic [31:0] HI_MASK = 32'hFFFF_E0FF;
    localparam logic [31:0] PM_MASK = 32'h01FF_E000;
    localparam logic [31:0] LO_MASK = 32'h03FF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WRITE      = 3'd1,
        S_READ       = 3'd2,
        S_READ_WAIT  = 3'd3,
        S_PROBE      = 3'd4,
        S_PROBE_WAIT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_TLBR  = 2'b00,
        OP_TLBWI = 2'b01,
        OP_TLBWR = 2'b10,
        OP_TLBP  = 2'b11
    } op_t;

    state_t           state_q, state_d;
    logic [31:0]      index_q, index_d;
    logic [IDX_W-1:0] random_q, random_d;
    logic [IDX_W-1:0] wired_q, wired_d;
    logic [31:0]      entryhi_q, entryhi_d;
    logic [31:0]      pagemask_q, pagemask_d;
    logic [31:0]      entrylo0_q, entrylo0_d;
    logic [31:0]      entrylo1_q, entrylo1_d;
    logic             use_rand_q, use_rand_d;
    logic [IDX_W-1:0] wr_rand_q, wr_rand_d;
    logic             mtc0_en;
    logic             global_bit;

    // Next-state, MTC0 commit, Random update and instruction side effects.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        wired_d    = wired_q;
        entryhi_d  = entryhi_q;
        pagemask_d = pagemask_q;
        entrylo0_d = entrylo0_q;
        entrylo1_d = entrylo1_q;
        use_rand_d = use_rand_q;
        wr_rand_d  = wr_rand_q;
        mtc0_en    = bus.cp0_we && (state_q == S_IDLE);

        // A Wired write restarts Random from the top, overriding the decrement.
        if (mtc0_en && (bus.cp0_addr == 5'd6)) begin
            random_d = IDX_MAX;
        end else if (random_q <= wired_q) begin
            random_d = IDX_MAX;
        end else begin
            random_d = random_q - IDX_W'(1);
        end

        if (mtc0_en) begin
            case (bus.cp0_addr)
                5'd0:    index_d    = {index_q[31], {(31-IDX_W){1'b0}}, bus.cp0_wdata[IDX_W-1:0]};
                5'd2:    entrylo0_d = bus.cp0_wdata & LO_MASK;
                5'd3:    entrylo1_d = bus.cp0_wdata & LO_MASK;
                5'd5:    pagemask_d = bus.cp0_wdata & PM_MASK;
                5'd6:    wired_d    = bus.cp0_wdata[IDX_W-1:0];
                5'd10:   entryhi_d  = bus.cp0_wdata & HI_MASK;
                default: index_d    = index_q;
            endcase
        end else begin
            index_d = index_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.inst_valid) begin
                    case (op_t'(bus.inst_op))
                        OP_TLBR:  state_d = S_READ;
                        OP_TLBWI: begin
                            state_d    = S_WRITE;
                            use_rand_d = 1'b0;
                        end
                        OP_TLBWR: begin
                            state_d    = S_WRITE;
                            use_rand_d = 1'b1;
                            wr_rand_d  = random_q;
                        end
                        OP_TLBP:  state_d = S_PROBE;
                        default:  state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE:     state_d = S_IDLE;
            S_READ:      state_d = S_READ_WAIT;
            S_READ_WAIT: begin
                entryhi_d  = bus.tlb_r_entryhi & HI_MASK;
                pagemask_d = bus.tlb_r_pagemask & PM_MASK;
                entrylo0_d = bus.tlb_r_entrylo0 & LO_MASK;
                entrylo1_d = bus.tlb_r_entrylo1 & LO_MASK;
                state_d    = S_IDLE;
            end
            S_PROBE:     state_d = S_PROBE_WAIT;
            S_PROBE_WAIT: begin
                if (bus.tlb_probe_hit) begin
                    index_d = {{(32-IDX_W){1'b0}}, bus.tlb_probe_idx};
                end else begin
                    index_d = {1'b1, index_q[30:0]};
                end
                state_d = S_IDLE;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    // State and architectural registers; rst returns everything to power-on values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            index_q    <= 32'h0;
            random_q   <= IDX_MAX;
            wired_q    <= {IDX_W{1'b0}};
            entryhi_q  <= 32'h0;
            pagemask_q <= 32'h0;
            entrylo0_q <= 32'h0;
            entrylo1_q <= 32'h0;
            use_rand_q <= 1'b0;
            wr_rand_q  <= {IDX_W{1'b0}};
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            random_q   <= random_d;
            wired_q    <= wired_d;
            entryhi_q  <= entryhi_d;
            pagemask_q <= pagemask_d;
            entrylo0_q <= entrylo0_d;
            entrylo1_q <= entrylo1_d;
            use_rand_q <= use_rand_d;
            wr_rand_q  <= wr_rand_d;
        end
    end

    // MFC0 read mux; unmapped register numbers read as zero.
    always_comb begin
        bus.cp0_rdata = 32'h0;
        case (bus.cp0_addr)
            5'd0:    bus.cp0_rdata = index_q;
            5'd1:    bus.cp0_rdata = {{(32-IDX_W){1'b0}}, random_q};
            5'd2:    bus.cp0_rdata = entrylo0_q;
            5'd3:    bus.cp0_rdata = entrylo1_q;
            5'd5:    bus.cp0_rdata = pagemask_q;
            5'd6:    bus.cp0_rdata = {{(32-IDX_W){1'b0}}, wired_q};
            5'd10:   bus.cp0_rdata = entryhi_q;
            default: bus.cp0_rdata = 32'h0;
        endcase
    end

    // TLB port drive. Strobes are masked by rst so an aborted op has no visible effect.
    always_comb begin
        global_bit        = entrylo0_q[0] & entrylo1_q[0];
        bus.busy          = (state_q != S_IDLE);
        bus.done          = ((state_q == S_WRITE) || (state_q == S_READ_WAIT) ||
                             (state_q == S_PROBE_WAIT)) && !rst;
        bus.tlb_we        = (state_q == S_WRITE) && !rst;
        bus.tlb_probe_req = (state_q == S_PROBE) && !rst;
        bus.tlb_widx      = use_rand_q ? wr_rand_q : index_q[IDX_W-1:0];
        bus.tlb_ridx      = index_q[IDX_W-1:0];
        bus.tlb_entryhi   = entryhi_q;
        bus.tlb_pagemask  = pagemask_q;
        bus.tlb_entrylo0  = {entrylo0_q[31:1], global_bit};
        bus.tlb_entrylo1  = {entrylo1_q[31:1], global_bit};
    end
endmodule

// File: tb/tb_cp0_tlb_ctrl.sv
// Scoreboard bench for cp0_tlb_ctrl: a phase-counting reference model pushes expected
// MFC0/busy values, done pulses and TLB writes; a negedge monitor pops and compares.
module tb_cp0_tlb_ctrl;
    localparam int IDX_W = 5;

    typedef struct {
        logic [31:0] rdata;
        logic        busy;
        logic [4:0]  addr;
        int          tag;
    } rd_t;

    typedef struct {
        int          cyc;
        logic [4:0]  idx;
        logic [31:0] hi;
        logic [31:0] pm;
        logic [31:0] lo0;
        logic [31:0] lo1;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic tb_end = 1'b0;

    rd_t rd_q[$];
    wr_t we_q[$];
    int  done_q[$];

    // reference model state
    logic [31:0] m_index, m_hi, m_pm, m_lo0, m_lo1;
    logic [4:0]  m_random, m_wired, m_wr_idx;
    logic [1:0]  m_op;
    int          m_phase;
    logic [31:0] t_hi[32], t_pm[32], t_lo0[32], t_lo1[32];
    logic        plan_hit;
    logic [4:0]  plan_idx;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val;
    int          ovr_tag;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cp0_tlb_ctrl_if #(.IDX_W(IDX_W)) bus ();
    cp0_tlb_ctrl #(.N_ENTRIES(32), .IDX_W(IDX_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Behavioural TLB: read data and probe result appear one cycle after the request.
    always @(posedge clk) begin
        bus.tlb_r_entryhi  <= t_hi[bus.tlb_ridx];
        bus.tlb_r_pagemask <= t_pm[bus.tlb_ridx];
        bus.tlb_r_entrylo0 <= t_lo0[bus.tlb_ridx];
        bus.tlb_r_entrylo1 <= t_lo1[bus.tlb_ridx];
        if (bus.tlb_probe_req) begin
            bus.tlb_probe_hit <= plan_hit;
            bus.tlb_probe_idx <= plan_idx;
        end
    end

    function automatic logic [31:0] m_view(input logic [4:0] a);
        case (a)
            5'd0:    return m_index;
            5'd1:    return {27'd0, m_random};
            5'd2:    return m_lo0;
            5'd3:    return m_lo1;
            5'd5:    return m_pm;
            5'd6:    return {27'd0, m_wired};
            5'd10:   return m_hi;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic is_write(input logic [1:0] op);
        return (op == 2'b01) || (op == 2'b10);
    endfunction

    task automatic push_exp();
        rd_t r;
        wr_t w;
        logic g;
        r.busy  = (m_phase != 0);
        r.addr  = bus.cp0_addr;
        r.rdata = ovr_en ? ovr_val : m_view(bus.cp0_addr);
        r.tag   = ovr_en ? ovr_tag : 0;
        ovr_en  = 1'b0;
        rd_q.push_back(r);
        if (!rst && m_phase != 0) begin
            if (is_write(m_op)) begin
                g     = m_lo0[0] & m_lo1[0];
                w.cyc = cyc;
                w.idx = (m_op == 2'b10) ? m_wr_idx : m_index[4:0];
                w.hi  = m_hi;
                w.pm  = m_pm;
                w.lo0 = {m_lo0[31:1], g};
                w.lo1 = {m_lo1[31:1], g};
                we_q.push_back(w);
                done_q.push_back(cyc);
            end else if (m_phase == 2) begin
                done_q.push_back(cyc);
            end
        end
    endtask

    task automatic model_edge();
        logic [4:0] nr;
        logic [4:0] i;
        logic       g;
        if (rst) begin
            m_index = 32'd0; m_random = 5'd31; m_wired = 5'd0;
            m_hi = 32'd0; m_pm = 32'd0; m_lo0 = 32'd0; m_lo1 = 32'd0;
            m_phase = 0;
            return;
        end
        if (m_phase == 0 && bus.cp0_we && bus.cp0_addr == 5'd6) nr = 5'd31;
        else if (m_random <= m_wired) nr = 5'd31;
        else nr = m_random - 5'd1;
        if (m_phase == 0 && bus.cp0_we) begin
            case (bus.cp0_addr)
                5'd0:    m_index = {m_index[31], 26'd0, bus.cp0_wdata[4:0]};
                5'd2:    m_lo0 = bus.cp0_wdata & 32'h03FF_FFFF;
                5'd3:    m_lo1 = bus.cp0_wdata & 32'h03FF_FFFF;
                5'd5:    m_pm = bus.cp0_wdata & 32'h01FF_E000;
                5'd6:    m_wired = bus.cp0_wdata[4:0];
                5'd10:   m_hi = bus.cp0_wdata & 32'hFFFF_E0FF;
                default: ;
            endcase
        end
        if (m_phase == 0) begin
            if (bus.inst_valid) begin
                m_op = bus.inst_op; m_wr_idx = m_random; m_phase = 1;
            end
        end else if (is_write(m_op)) begin
            i = (m_op == 2'b10) ? m_wr_idx : m_index[4:0];
            g = m_lo0[0] & m_lo1[0];
            t_hi[i] = m_hi; t_pm[i] = m_pm;
            t_lo0[i] = {m_lo0[31:1], g}; t_lo1[i] = {m_lo1[31:1], g};
            m_phase = 0;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            if (m_op == 2'b00) begin
                i = m_index[4:0];
                m_hi = t_hi[i] & 32'hFFFF_E0FF;
                m_pm = t_pm[i] & 32'h01FF_E000;
                m_lo0 = t_lo0[i] & 32'h03FF_FFFF;
                m_lo1 = t_lo1[i] & 32'h03FF_FFFF;
            end else if (plan_hit) begin
                m_index = {27'd0, plan_idx};
            end else begin
                m_index[31] = 1'b1;
            end
            m_phase = 0;
        end
        m_random = nr;
    endtask

    task automatic step();
        push_exp();
        model_edge();
        @(posedge clk);
        #2;
        bus.inst_valid = 1'b0;
        bus.cp0_we     = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.cp0_we = 1'b1; bus.cp0_addr = a; bus.cp0_wdata = d;
        step();
    endtask

    task automatic issue(input logic [1:0] op);
        bus.inst_valid = 1'b1; bus.inst_op = op;
        step();
    endtask

    task automatic expect_read(input logic [4:0] a, input logic [31:0] v, input int tag);
        bus.cp0_addr = a; ovr_en = 1'b1; ovr_val = v; ovr_tag = tag;
        step();
    endtask

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        bus.inst_valid = 1'b0; bus.inst_op = 2'b00; bus.cp0_we = 1'b0;
        bus.cp0_addr = 5'd0; bus.cp0_wdata = 32'd0;
        plan_hit = 1'b0; plan_idx = 5'd0; m_op = 2'b00; m_phase = 0;
        for (int i = 0; i < 32; i++) begin
            t_hi[i] = $urandom; t_pm[i] = $urandom; t_lo0[i] = $urandom; t_lo1[i] = $urandom;
        end
        t_hi[3] = 32'hFFFF_FFFF;
        @(posedge clk);
        #2;
        model_edge();
        @(posedge clk);
        #2;
        step();
        rst = 1'b0;

        // Random countdown from 31 with Wired=0, wrapping after 0
        for (int k = 0; k < 40; k++) begin
            bus.cp0_addr = 5'd1;
            if (k == 0 || k == 32) begin ovr_en = 1'b1; ovr_val = 32'd31; ovr_tag = 1; end
            if (k == 31) begin ovr_en = 1'b1; ovr_val = 32'd0; ovr_tag = 2; end
            step();
        end

        mtc0(5'd0, 32'd5);
        mtc0(5'd10, 32'h0040_2011);
        mtc0(5'd2, 32'h0000_0107);
        mtc0(5'd3, 32'h0000_0146);
        issue(2'b01);
        step();
        expect_read(5'd2, 32'h0000_0107, 3);

        plan_hit = 1'b1; plan_idx = 5'd7;
        issue(2'b11);
        step(); step();
        expect_read(5'd0, 32'h0000_0007, 4);
        plan_hit = 1'b0; plan_idx = 5'd12;
        issue(2'b11);
        step(); step();
        expect_read(5'd0, 32'h8000_0007, 5);

        mtc0(5'd6, 32'd4);
        expect_read(5'd1, 32'd31, 6);
        for (int k = 0; k < 64 && m_random != 5'd9; k++) begin
            bus.cp0_addr = 5'd1;
            step();
        end
        bus.cp0_addr = 5'd1; ovr_en = 1'b1; ovr_val = 32'd9; ovr_tag = 7;
        issue(2'b10);
        for (int k = 0; k < 40; k++) begin
            bus.cp0_addr = 5'd1;
            step();
        end

        mtc0(5'd0, 32'd3);
        issue(2'b00);
        step(); step();
        expect_read(5'd10, 32'hFFFF_E0FF, 8);

        rst = 1'b1; step(); rst = 1'b0;
        plan_hit = 1'b1; plan_idx = 5'd9;
        issue(2'b11);
        step();
        rst = 1'b1; bus.cp0_addr = 5'd0;
        step();
        rst = 1'b0;
        expect_read(5'd0, 32'd0, 9);

        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 7))
                0: bus.cp0_addr = 5'd0;
                1: bus.cp0_addr = 5'd1;
                2: bus.cp0_addr = 5'd2;
                3: bus.cp0_addr = 5'd3;
                4: bus.cp0_addr = 5'd5;
                5: bus.cp0_addr = 5'd6;
                6: bus.cp0_addr = 5'd10;
                default: bus.cp0_addr = 5'($urandom_range(0, 31));
            endcase
            bus.cp0_we = ($urandom_range(0, 3) == 0);
            bus.cp0_wdata = $urandom;
            if (m_phase == 0 && $urandom_range(0, 2) == 0) begin
                bus.inst_valid = 1'b1;
                bus.inst_op = 2'($urandom_range(0, 3));
                plan_hit = 1'($urandom_range(0, 1));
                plan_idx = 5'($urandom_range(0, 31));
            end else if ($urandom_range(0, 4) == 0) begin
                bus.inst_valid = 1'b1;
                bus.inst_op = 2'($urandom_range(0, 3));
            end
            step();
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step();
        @(negedge clk);
        #1;
        tb_end = 1'b1;
    end

    // Monitor: pops and compares whenever the DUT presents read data, done or a TLB write.
    initial begin
        rd_t r;
        wr_t w;
        int  c;
        forever begin
            @(negedge clk);
            if (tb_end) break;
            if (rd_q.size() > 0) begin
                r = rd_q.pop_front();
                n_tests++;
                if (bus.cp0_rdata !== r.rdata || bus.busy !== r.busy) begin
                    n_fail++;
                    $display("FAIL rdata tag=%0d cyc=%0d addr=%0d got rdata=%h busy=%b want rdata=%h busy=%b",
                             r.tag, cyc, r.addr, bus.cp0_rdata, bus.busy, r.rdata, r.busy);
                end
            end
            if (bus.done === 1'b1) begin
                n_tests++;
                if (done_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected cyc=%0d got done=1 want done=0", cyc);
                end else begin
                    c = done_q.pop_front();
                    if (c != cyc) begin
                        n_fail++;
                        $display("FAIL done_timing got cyc=%0d want cyc=%0d", cyc, c);
                    end
                end
            end else if (bus.done !== 1'b0 || (done_q.size() > 0 && done_q[0] <= cyc)) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_missing cyc=%0d got done=%b want done=1", cyc, bus.done);
                if (done_q.size() > 0) c = done_q.pop_front();
            end
            if (bus.tlb_we === 1'b1) begin
                n_tests++;
                if (we_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL we_unexpected cyc=%0d got tlb_we=1 want tlb_we=0", cyc);
                end else begin
                    w = we_q.pop_front();
                    if (w.cyc != cyc || bus.tlb_widx !== w.idx || bus.tlb_entryhi !== w.hi ||
                        bus.tlb_pagemask !== w.pm || bus.tlb_entrylo0 !== w.lo0 ||
                        bus.tlb_entrylo1 !== w.lo1) begin
                        n_fail++;
                        $display("FAIL tlb_write cyc=%0d got idx=%0d hi=%h pm=%h lo0=%h lo1=%h want cyc=%0d idx=%0d hi=%h pm=%h lo0=%h lo1=%h",
                                 cyc, bus.tlb_widx, bus.tlb_entryhi, bus.tlb_pagemask, bus.tlb_entrylo0,
                                 bus.tlb_entrylo1, w.cyc, w.idx, w.hi, w.pm, w.lo0, w.lo1);
                    end
                end
            end else if (bus.tlb_we !== 1'b0 || (we_q.size() > 0 && we_q[0].cyc <= cyc)) begin
                n_tests++;
                n_fail++;
                $display("FAIL we_missing cyc=%0d got tlb_we=%b want tlb_we=1", cyc, bus.tlb_we);
                if (we_q.size() > 0) w = we_q.pop_front();
            end
        end
        n_tests++;
        if (rd_q.size() != 0 || done_q.size() != 0 || we_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover got rd=%0d done=%0d we=%0d want all 0",
                     rd_q.size(), done_q.size(), we_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
